// File: rtl/execute_writeback_unit.sv
// Execute stage + EX/WB pipeline register + 32x32 register file with two async read ports.
// Latency: ID/EX inputs appear on wb_* one cycle later; the regfile commit lands on the following edge.
// Backpressure: stall holds EX/WB and suppresses commit; optional bypass via EXWB_BYPASS_EN.
module execute_writeback_unit #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            register_write_en_in,
    input  logic [2:0]      alu_op_in,
    input  logic [XLEN-1:0] alu_operand1_in,
    input  logic [XLEN-1:0] alu_operand2_in,
    input  logic [4:0]      register_write_addr_in,
    input  logic            stall,
    input  logic [4:0]      read_addr1,
    input  logic [4:0]      read_addr2,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2,
    output logic            wb_valid,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_SLT = 3'b111
    } alu_op_t;

    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] regs [REG_COUNT];
    logic            slt_lt;

    assign slt_lt = $signed(alu_operand1_in) < $signed(alu_operand2_in);

    // ALU: purely combinational on the ID/EX register outputs; add/sub wrap.
    always_comb begin
        alu_result = '0;
        case (alu_op_t'(alu_op_in))
            OP_ADD:  alu_result = alu_operand1_in + alu_operand2_in;
            OP_SUB:  alu_result = alu_operand1_in - alu_operand2_in;
            OP_AND:  alu_result = alu_operand1_in & alu_operand2_in;
            OP_OR:   alu_result = alu_operand1_in | alu_operand2_in;
            OP_XOR:  alu_result = alu_operand1_in ^ alu_operand2_in;
            OP_SLL:  alu_result = alu_operand1_in << alu_operand2_in[4:0];
            OP_SRL:  alu_result = alu_operand1_in >> alu_operand2_in[4:0];
            OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, slt_lt};
            default: alu_result = '0;
        endcase
    end

    // EX/WB register: loads every unstalled cycle; writes to x0 never become valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else if (!stall) begin
            wb_valid <= register_write_en_in && (register_write_addr_in != 5'd0);
            wb_addr  <= register_write_addr_in;
            wb_data  <= alu_result;
        end
    end

    // Register file commit: drains EX/WB on the same edge the next instruction loads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (!stall && wb_valid) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Read ports: x0 hardwired to zero; pending EX/WB result forwarded when bypass is built in.
    always_comb begin
        read_data1 = (read_addr1 == 5'd0) ? '0 : regs[read_addr1];
        read_data2 = (read_addr2 == 5'd0) ? '0 : regs[read_addr2];
`ifdef EXWB_BYPASS_EN
        if (wb_valid && (read_addr1 != 5'd0) && (read_addr1 == wb_addr)) begin
            read_data1 = wb_data;
        end
        if (wb_valid && (read_addr2 != 5'd0) && (read_addr2 == wb_addr)) begin
            read_data2 = wb_data;
        end
`else
        // Without bypass the read ports see committed state only.
`endif
    end

endmodule
